// File: rtl/booth_mult_seq.sv
// Sequential signed 32x32 radix-2 Booth multiplier: one shared cla_32 add/subtract per cycle,
// producing the low product word plus a signed-32 overflow flag under a start/ready handshake.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module cla_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Full lookahead inside each 4-bit group, group carries ripple between groups.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 32; k += 4) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
      w_c[k+2] = w_g[k+1] | (w_p[k+1] & w_g[k]) | (w_p[k+1] & w_p[k] & w_c[k]);
      w_c[k+3] = w_g[k+2] | (w_p[k+2] & w_g[k+1]) | (w_p[k+2] & w_p[k+1] & w_g[k])
               | (w_p[k+2] & w_p[k+1] & w_p[k] & w_c[k]);
      w_c[k+4] = w_g[k+3] | (w_p[k+3] & w_g[k+2]) | (w_p[k+3] & w_p[k+2] & w_g[k+1])
               | (w_p[k+3] & w_p[k+2] & w_p[k+1] & w_g[k])
               | (w_p[k+3] & w_p[k+2] & w_p[k+1] & w_p[k] & w_c[k]);
    end
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];
endmodule

module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH:0]       r_acc;
  logic [WIDTH-1:0]     r_plier;
  logic                 r_q_m1;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;
  logic                 r_rdy;
  logic                 r_busy;

  logic                 w_sub;
  logic                 w_do_op;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum_lo;
  logic                 w_cout_lo;
  logic                 w_sum_hi;
  logic                 w_unused_cout;
  logic [WIDTH:0]       w_acc_op;
  logic signed [2*WIDTH+1:0] w_cat;
  logic signed [2*WIDTH+1:0] w_shift;
  logic [WIDTH:0]       w_acc_nxt;
  logic [WIDTH-1:0]     w_plier_nxt;
  logic                 w_q_nxt;
  logic                 w_exc_nxt;

  // Subtraction reuses the adder as acc + ~mcand + 1; bit 32 extends the sign of the addend.
  assign w_sub    = r_plier[0] & ~r_q_m1;
  assign w_do_op  = r_plier[0] ^ r_q_m1;
  assign w_addend = w_sub ? ~r_mcand : r_mcand;

  cla_32 u_cla (
    .i_a    (r_acc[WIDTH-1:0]),
    .i_b    (w_addend),
    .i_cin  (w_sub),
    .o_sum  (w_sum_lo),
    .o_cout (w_cout_lo)
  );

  full_adder u_fa_hi (
    .i_a    (r_acc[WIDTH]),
    .i_b    (w_addend[WIDTH-1]),
    .i_cin  (w_cout_lo),
    .o_sum  (w_sum_hi),
    .o_cout (w_unused_cout)
  );

  assign w_acc_op    = w_do_op ? {w_sum_hi, w_sum_lo} : r_acc;
  assign w_cat       = {w_acc_op, r_plier, r_q_m1};
  assign w_shift     = w_cat >>> 1;
  assign w_acc_nxt   = w_shift[2*WIDTH+1:WIDTH+1];
  assign w_plier_nxt = w_shift[WIDTH:1];
  assign w_q_nxt     = w_shift[0];
  // Product fits in signed 32 only if the whole upper half is a copy of the low word's sign.
  assign w_exc_nxt   = (w_acc_nxt != {(WIDTH+1){w_plier_nxt[WIDTH-1]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_plier  <= '0;
      r_q_m1   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT) begin
        r_mcand <= data_operandA;
        r_acc   <= '0;
        r_plier <= data_operandB;
        r_q_m1  <= 1'b0;
        r_cnt   <= '0;
        r_state <= S_RUN;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_RUN: begin
            r_acc   <= w_acc_nxt;
            r_plier <= w_plier_nxt;
            r_q_m1  <= w_q_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH-1)) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_result <= w_plier_nxt;
              r_exc    <= w_exc_nxt;
              r_rdy    <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_IDLE:  r_state <= S_IDLE;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Multicycle signed 32x32 radix-2 Booth multiplier for the processor's multdiv path.
- Sequences a single shared cla_32 instance, one add, subtract or skip per cycle, instead of a combinational array.
- Produces the low 32 bits of the product plus an overflow exception, under a start/ready handshake toward the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported because the adder is cla_32; the parameter exists for counter sizing.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_MULT  input  1  single-cycle start pulse; operands are sampled on the same edge.
- data_operandA  input  32  multiplicand, two's complement.
- data_operandB  input  32  multiplier, two's complement.
- data_result  output  32  low 32 bits of A*B; held until the next start.
- data_exception  output  1  high when the true 64-bit product does not fit in signed 32 bits; held with data_result.
- data_resultRDY  output  1  one-cycle pulse when data_result is valid.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, counter=0, all internal registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Internal registers:
  - mcand[31:0]
  - acc[32:0], the 33-bit upper half; the extra bit absorbs the A=-2^31 case.
  - plier[31:0]
  - q_m1, one bit.
- States:
  - IDLE to RUN: on ctrl_MULT.
  - RUN to DONE: when counter==31 at a clock edge, i.e. after the 32nd iteration.
  - DONE to IDLE: unconditionally after one cycle.
- Start (ctrl_MULT=1 at an edge, any state):
  - mcand=A, acc=0, plier=B, q_m1=0, counter=0, state=RUN.
  - A start during RUN or DONE aborts the current operation and restarts with the new operands. The aborted operation never asserts data_resultRDY.
- RUN iteration, one per cycle, selected by {plier[0], q_m1}:
  - 01: acc = acc + sext(mcand).
  - 10: acc = acc - sext(mcand). Low 32 bits come from cla_32 with B=~mcand, Cin=1; bit 32 comes from a full_adder fed by the cla_32 carry-out.
  - 00 or 11: acc unchanged.
  - Then a 66-bit arithmetic right shift of {acc, plier, q_m1}; acc[32] is replicated.
  - counter increments by 1.
- Timing: with start sampled at edge k, iterations occur at edges k+1..k+32. DONE is the cycle after edge k+32, and data_resultRDY is high for exactly that cycle.
- Output registers:
  - On entry to DONE: data_result = final plier.
  - data_exception = NOT(acc[32:0] all equal to plier[31]).
  - Both hold their values through IDLE until the next completion or reset.
  - A start clears neither.
- busy=1 exactly in RUN. A start pulse asserted while busy=1 restarts as above and does not extend the current operation.
- Boundary conditions:
  - No internal overflow for any operand pair, including A=B=-2^31.
  - The counter never wraps; RUN exits at 31.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. The first clock after reset_n rises does nothing unless ctrl_MULT=1.
- ctrl_MULT held high for several cycles re-samples every cycle, so the operation restarts each cycle. Callers must pulse it.

Test Plan:
- Start A=3, B=4 -> RDY pulses exactly 33 cycles after the start edge; result=0x0000000C, exception=0; busy high for 32 cycles.
- A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6 (-42), exception=0. Also A=0, B=0x12345678 -> result=0, exception=0.
- A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1. A=0x00010000, B=0x00010000 -> result=0, exception=1.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0. A=B=0x80000000 -> result=0, exception=1.
- Start 5*5, then at cycle 10 start 9*(-3) -> no RDY for the first operation; RDY 33 cycles after the second start with result=0xFFFFFFE5, exception=0.
- Pull reset_n low at cycle 15 of an operation, mid-cycle between edges -> outputs immediately 0 and busy=0. After release, no RDY appears without a new start; a new 2*2 completes with result=4.
